// File: rtl/ttl_pulse_train_gen.sv
// ttl_pulse_train_gen
//
// Multi-channel TTL pulse train generator. Each channel runs its own IDLE/DELAY/HIGH/LOW
// FSM and produces N pulses (or an endless train when N=0) with programmable start delay,
// high time and period. All config fields are captured into shadow registers when a start
// is accepted, so changing them mid-train has no effect.
//
// Optional feature macro: TTL_PULSE_POLARITY_EN
//   Adds a per-channel polarity input, latched at start. A latched 1 inverts the channel
//   output and sets its idle level to 1.
//
// Ports:
//   clk           system clock, rising edge
//   rst           synchronous active-high reset
//   start         per-channel start request (level sampled, accepted only in IDLE)
//   abort         per-channel immediate stop (wins over start)
//   pulse_delay   per-channel start delay in cycles      [i*CNT_W +: CNT_W]
//   pulse_width   per-channel high time in cycles        [i*CNT_W +: CNT_W]
//   pulse_period  per-channel period in cycles           [i*CNT_W +: CNT_W]
//   pulse_count   per-channel pulses per train, 0 = run until abort [i*NUM_W +: NUM_W]
//   polarity      per-channel output inversion (TTL_PULSE_POLARITY_EN only)
//   ttl_out       registered TTL outputs
//   busy          channel running a train
//   done          one-cycle strobe when a finite train completes
module ttl_pulse_train_gen #(
  parameter int unsigned CHANNELS = 2,
  parameter int unsigned CNT_W    = 32,
  parameter int unsigned NUM_W    = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS-1:0]       start,
  input  logic [CHANNELS-1:0]       abort,
  input  logic [CHANNELS*CNT_W-1:0] pulse_delay,
  input  logic [CHANNELS*CNT_W-1:0] pulse_width,
  input  logic [CHANNELS*CNT_W-1:0] pulse_period,
  input  logic [CHANNELS*NUM_W-1:0] pulse_count,
`ifdef TTL_PULSE_POLARITY_EN
  input  logic [CHANNELS-1:0]       polarity,
`endif
  output logic [CHANNELS-1:0]       ttl_out,
  output logic [CHANNELS-1:0]       busy,
  output logic [CHANNELS-1:0]       done
);

  typedef enum logic [1:0] {StIdle, StDelay, StHigh, StLow} state_e;

  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);
  localparam logic [NUM_W-1:0] NumOne = NUM_W'(1);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    state_e           state_q, state_d;
    logic [CNT_W-1:0] dly_q, dly_d;
    logic [CNT_W-1:0] wid_q, wid_d;   // effective high time, already clamped to period
    logic [CNT_W-1:0] per_q, per_d;   // effective period, at least 1
    logic [CNT_W-1:0] cnt_q, cnt_d;   // cycles elapsed in DELAY, or within current period
    logic [NUM_W-1:0] rem_q, rem_d;   // pulses still to finish, including the current one
    logic             cont_q, cont_d; // continuous train, rem_q unused
    logic             ttl_q, ttl_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pol_d;
    logic             accept;
    logic             finish;

    logic [CNT_W-1:0] cfg_dly, cfg_wid, cfg_per, eff_per, eff_wid;
    logic [NUM_W-1:0] cfg_cnt;

    assign cfg_dly = pulse_delay[i*CNT_W +: CNT_W];
    assign cfg_wid = pulse_width[i*CNT_W +: CNT_W];
    assign cfg_per = pulse_period[i*CNT_W +: CNT_W];
    assign cfg_cnt = pulse_count[i*NUM_W +: NUM_W];

    // Normalise at capture so the running FSM only ever sees 1 <= per and wid <= per.
    assign eff_per = (cfg_per == '0) ? CntOne : cfg_per;
    assign eff_wid = (cfg_wid > eff_per) ? eff_per : cfg_wid;

    assign accept = (state_q == StIdle) && start[i] && !abort[i];

`ifdef TTL_PULSE_POLARITY_EN
    logic pol_q;

    assign pol_d = accept ? polarity[i] : pol_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        pol_q <= 1'b0;
      end else begin
        pol_q <= pol_d;
      end
    end
`else
    assign pol_d = 1'b0;
`endif

    // State and shadow registers.
    always_ff @(posedge clk) begin
      if (rst) begin
        state_q <= StIdle;
        dly_q   <= '0;
        wid_q   <= '0;
        per_q   <= '0;
        cnt_q   <= '0;
        rem_q   <= '0;
        cont_q  <= 1'b0;
      end else begin
        state_q <= state_d;
        dly_q   <= dly_d;
        wid_q   <= wid_d;
        per_q   <= per_d;
        cnt_q   <= cnt_d;
        rem_q   <= rem_d;
        cont_q  <= cont_d;
      end
    end

    // Next-state logic.
    always_comb begin
      state_d = state_q;
      dly_d   = dly_q;
      wid_d   = wid_q;
      per_d   = per_q;
      cnt_d   = cnt_q;
      rem_d   = rem_q;
      cont_d  = cont_q;
      finish  = 1'b0;

      unique case (state_q)
        StIdle: begin
          if (accept) begin
            dly_d  = cfg_dly;
            wid_d  = eff_wid;
            per_d  = eff_per;
            rem_d  = cfg_cnt;
            cont_d = (cfg_cnt == '0);
            cnt_d  = '0;
            if (cfg_dly != '0) begin
              state_d = StDelay;
            end else begin
              state_d = (eff_wid == '0) ? StLow : StHigh;
            end
          end
        end

        StDelay: begin
          if (cnt_q == dly_q - CntOne) begin
            cnt_d   = '0;
            state_d = (wid_q == '0) ? StLow : StHigh;
          end else begin
            cnt_d = cnt_q + CntOne;
          end
        end

        StHigh, StLow: begin
          if (cnt_q == per_q - CntOne) begin
            // End of period; with wid == per this fires from HIGH and LOW is never visited.
            cnt_d = '0;
            if (!cont_q && rem_q == NumOne) begin
              state_d = StIdle;
              finish  = 1'b1;
            end else begin
              if (!cont_q) begin
                rem_d = rem_q - NumOne;
              end
              state_d = (wid_q == '0) ? StLow : StHigh;
            end
          end else begin
            cnt_d = cnt_q + CntOne;
            if (state_q == StHigh && cnt_q == wid_q - CntOne) begin
              state_d = StLow;
            end
          end
        end

        default: state_d = StIdle;
      endcase

      if (abort[i] && state_q != StIdle) begin
        state_d = StIdle;
        cnt_d   = '0;
        finish  = 1'b0;
      end
    end

    // Output decode from the upcoming state, so the registered outputs line up with it.
    always_comb begin
      ttl_d  = (state_d == StHigh) ^ pol_d;
      busy_d = (state_d != StIdle);
      done_d = finish;
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        ttl_q  <= 1'b0;
        busy_q <= 1'b0;
        done_q <= 1'b0;
      end else begin
        ttl_q  <= ttl_d;
        busy_q <= busy_d;
        done_q <= done_d;
      end
    end

    assign ttl_out[i] = ttl_q;
    assign busy[i]    = busy_q;
    assign done[i]    = done_q;
  end

endmodule

// File: tb/tb_ttl_pulse_train_gen.sv
// Self-checking bench for ttl_pulse_train_gen. Expected outputs come from a closed-form
// model of each train: given its start cycle and latched D/H/P/N, the outputs in any cycle
// follow directly from the timing rules.
module tb_ttl_pulse_train_gen;
  localparam int CH = 2;
  localparam int CW = 32;
  localparam int NW = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic [CH-1:0]     start;
  logic [CH-1:0]     abort;
  logic [CH*CW-1:0]  pulse_delay;
  logic [CH*CW-1:0]  pulse_width;
  logic [CH*CW-1:0]  pulse_period;
  logic [CH*NW-1:0]  pulse_count;
  logic [CH-1:0]     ttl_out;
  logic [CH-1:0]     busy;
  logic [CH-1:0]     done;

  ttl_pulse_train_gen #(
    .CHANNELS (CH),
    .CNT_W    (CW),
    .NUM_W    (NW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .abort        (abort),
    .pulse_delay  (pulse_delay),
    .pulse_width  (pulse_width),
    .pulse_period (pulse_period),
    .pulse_count  (pulse_count),
`ifdef TTL_PULSE_POLARITY_EN
    .polarity     ('0),
`endif
    .ttl_out      (ttl_out),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  int    n_checks = 0;
  int    n_pass   = 0;
  longint cyc     = 0;

  // Reference model: one record per channel describing the train in progress (if any).
  bit     m_run [CH];
  longint m_s [CH];
  longint m_d [CH];
  longint m_h [CH];
  longint m_p [CH];
  longint m_n [CH];
  logic [CH-1:0] exp_ttl, exp_busy, exp_done;

  function automatic bit m_busy(int ch, longint c);
    longint rel;
    rel = c - m_s[ch];
    if (!m_run[ch] || rel < 1) return 1'b0;
    return (m_n[ch] == 0) || (rel <= m_d[ch] + m_n[ch] * m_p[ch]);
  endfunction

  function automatic bit m_done(int ch, longint c);
    longint rel;
    rel = c - m_s[ch];
    return m_run[ch] && (m_n[ch] != 0) && (rel == m_d[ch] + m_n[ch] * m_p[ch] + 1);
  endfunction

  function automatic bit m_ttl(int ch, longint c);
    longint rel;
    rel = c - m_s[ch];
    if (!m_busy(ch, c) || rel <= m_d[ch]) return 1'b0;
    return ((rel - m_d[ch] - 1) % m_p[ch]) < m_h[ch];
  endfunction

  task automatic model_eval();
    for (int ch = 0; ch < CH; ch++) begin
      exp_ttl[ch]  = m_ttl(ch, cyc);
      exp_busy[ch] = m_busy(ch, cyc);
      exp_done[ch] = m_done(ch, cyc);
    end
  endtask

  // Apply the inputs present during cycle cyc to the model.
  task automatic model_step();
    longint p, w;
    for (int ch = 0; ch < CH; ch++) begin
      if (rst) begin
        m_run[ch] = 1'b0;
      end else if (m_busy(ch, cyc)) begin
        if (abort[ch]) m_run[ch] = 1'b0;
      end else if (start[ch] && !abort[ch]) begin
        m_run[ch] = 1'b1;
        m_s[ch]   = cyc;
        m_d[ch]   = longint'(pulse_delay[ch*CW +: CW]);
        p         = longint'(pulse_period[ch*CW +: CW]);
        w         = longint'(pulse_width[ch*CW +: CW]);
        m_p[ch]   = (p == 0) ? 1 : p;
        m_h[ch]   = (w > m_p[ch]) ? m_p[ch] : w;
        m_n[ch]   = longint'(pulse_count[ch*NW +: NW]);
      end
    end
  endtask

  // Inputs are changed at the falling edge; outputs are sampled at the falling edge.
  task automatic tick();
    model_step();
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic set_cfg(input int ch, input int d, input int w, input int p, input int n);
    pulse_delay[ch*CW +: CW]  = CW'(d);
    pulse_width[ch*CW +: CW]  = CW'(w);
    pulse_period[ch*CW +: CW] = CW'(p);
    pulse_count[ch*NW +: NW]  = NW'(n);
  endtask

  task automatic quiesce();
    start = '0;
    abort = '1;
    tick();
    abort = '0;
    tick();
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    start = '1;
    abort = '0;
    set_cfg(0, 0, 3, 10, 2);
    set_cfg(1, 1, 1, 2, 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      model_eval();
      n_checks++;
      if ({ttl_out, busy, done} !== {exp_ttl, exp_busy, exp_done})
        $display("FAIL reset cyc=%0d got ttl=%b busy=%b done=%b want ttl=%b busy=%b done=%b",
                 cyc, ttl_out, busy, done, exp_ttl, exp_busy, exp_done);
      else n_pass++;
    end
    rst   = 1'b0;
    start = '0;
    tick();
  endtask

  // D, H, P, N per run: narrow pulses, width > period, zero width.
  task automatic test_finite_trains();
    int cfg [3][4] = '{'{0, 3, 10, 2}, '{5, 10, 4, 3}, '{0, 0, 4, 2}};
    for (int r = 0; r < 3; r++) begin
      quiesce();
      set_cfg(0, cfg[r][0], cfg[r][1], cfg[r][2], cfg[r][3]);
      set_cfg(1, 1, 1, 2, 1);
      for (int k = 0; k <= cfg[r][0] + cfg[r][3] * 10 + 4; k++) begin
        start = (k == 0) ? 2'b01 : 2'b00;
        tick();
        model_eval();
        n_checks++;
        if ({ttl_out, busy, done} !== {exp_ttl, exp_busy, exp_done})
          $display("FAIL finite_train run=%0d k=%0d got ttl=%b busy=%b done=%b want ttl=%b busy=%b done=%b",
                   r, k + 1, ttl_out, busy, done, exp_ttl, exp_busy, exp_done);
        else n_pass++;
      end
    end
  endtask

  task automatic test_continuous_abort();
    quiesce();
    set_cfg(0, 0, 2, 5, 0);
    for (int k = 0; k < 32; k++) begin
      start = (k == 0) ? 2'b01 : 2'b00;
      abort = (k == 23) ? 2'b01 : 2'b00;
      tick();
      model_eval();
      n_checks++;
      if ({ttl_out, busy, done} !== {exp_ttl, exp_busy, exp_done})
        $display("FAIL continuous_abort k=%0d got ttl=%b busy=%b done=%b want ttl=%b busy=%b done=%b",
                 k + 1, ttl_out, busy, done, exp_ttl, exp_busy, exp_done);
      else n_pass++;
    end
    abort = '0;
  endtask

  task automatic test_independent();
    quiesce();
    set_cfg(0, 0, 1, 3, 4);
    set_cfg(1, 0, 2, 4, 1);
    for (int k = 0; k < 18; k++) begin
      start[0] = (k == 0 || k == 6);
      start[1] = (k == 4);
      // Scribble ch0 config while it runs; the latched copy must be kept.
      if (k == 2) set_cfg(0, 3, 7, 9, 1);
      tick();
      model_eval();
      n_checks++;
      if ({ttl_out, busy, done} !== {exp_ttl, exp_busy, exp_done})
        $display("FAIL independent k=%0d got ttl=%b busy=%b done=%b want ttl=%b busy=%b done=%b",
                 k + 1, ttl_out, busy, done, exp_ttl, exp_busy, exp_done);
      else n_pass++;
    end
    start = '0;
  endtask

  task automatic test_reset_mid_train();
    quiesce();
    set_cfg(0, 0, 3, 10, 2);
    set_cfg(1, 0, 1, 2, 0);
    for (int k = 0; k < 24; k++) begin
      start = (k == 0) ? 2'b11 : (k == 9) ? 2'b01 : 2'b00;
      rst   = (k == 7);
      if (k == 9) set_cfg(0, 2, 1, 3, 2);
      tick();
      model_eval();
      n_checks++;
      if ({ttl_out, busy, done} !== {exp_ttl, exp_busy, exp_done})
        $display("FAIL reset_mid_train k=%0d got ttl=%b busy=%b done=%b want ttl=%b busy=%b done=%b",
                 k + 1, ttl_out, busy, done, exp_ttl, exp_busy, exp_done);
      else n_pass++;
    end
    rst   = 1'b0;
    start = '0;
  endtask

  // Start held high: each train restarts in its own done cycle. Also start+abort in IDLE.
  task automatic test_back_to_back();
    quiesce();
    set_cfg(0, 0, 1, 2, 1);
    set_cfg(1, 1, 2, 2, 2);
    for (int k = 0; k < 30; k++) begin
      start = (k < 20) ? 2'b11 : 2'b00;
      abort = (k >= 24 && k < 26) ? 2'b11 : 2'b00;
      if (k >= 24) start = 2'b11;
      tick();
      model_eval();
      n_checks++;
      if ({ttl_out, busy, done} !== {exp_ttl, exp_busy, exp_done})
        $display("FAIL back_to_back k=%0d got ttl=%b busy=%b done=%b want ttl=%b busy=%b done=%b",
                 k + 1, ttl_out, busy, done, exp_ttl, exp_busy, exp_done);
      else n_pass++;
    end
    start = '0;
    abort = '0;
  endtask

  task automatic test_random();
    quiesce();
    for (int k = 0; k < 3000; k++) begin
      for (int ch = 0; ch < CH; ch++) begin
        set_cfg(ch, ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 6)),
                int'($urandom_range(0, 12)), int'($urandom_range(0, 8)),
                int'($urandom_range(0, 4)));
        start[ch] = ($urandom_range(0, 3) == 0);
        abort[ch] = ($urandom_range(0, 24) == 0);
      end
      rst = ($urandom_range(0, 299) == 0);
      tick();
      model_eval();
      n_checks++;
      if ({ttl_out, busy, done} !== {exp_ttl, exp_busy, exp_done})
        $display("FAIL random k=%0d got ttl=%b busy=%b done=%b want ttl=%b busy=%b done=%b",
                 k + 1, ttl_out, busy, done, exp_ttl, exp_busy, exp_done);
      else n_pass++;
    end
    rst   = 1'b0;
    start = '0;
    abort = '0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    for (int ch = 0; ch < CH; ch++) begin
      m_run[ch] = 1'b0;
      m_s[ch]   = 0;
      m_d[ch]   = 0;
      m_h[ch]   = 0;
      m_p[ch]   = 1;
      m_n[ch]   = 0;
    end
    rst          = 1'b1;
    start        = '0;
    abort        = '0;
    pulse_delay  = '0;
    pulse_width  = '0;
    pulse_period = '0;
    pulse_count  = '0;
    @(negedge clk);
    test_reset();
    test_finite_trains();
    test_continuous_abort();
    test_independent();
    test_reset_mid_train();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
